hex_display_scan: RTL and testbench

- Downstream stage of the Wishbone hex display. Consumes its four 8-bit segment patterns and drives one shared segment bus plus four digit enables by time-multiplexing the digits.
- Adds inter-digit blanking to suppress ghosting, and 16-level brightness via per-slot PWM.
- Sits at the board pin boundary; all outputs are registered.

---
 rtl/hex_display_pkg.sv | 14 +
 rtl/hex_scan_timer.sv | 59 +++++
 rtl/hex_display_scan.sv | 136 +++++++++++++
 tb/tb_hex_display_scan.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/hex_display_pkg.sv
// Shared types and constants for the multiplexed hex display scanner.
package hex_display_pkg;

  typedef enum logic [0:0] {ST_BLANK, ST_ON} state_e;

  localparam int unsigned PWM_STEPS  = 16;
  localparam int unsigned NUM_DIGITS = 4;

  // Segment bus value while no digit is driven.
  function automatic logic [7:0] seg_idle(input bit active_low);
    return active_low ? 8'hFF : 8'h00;
  endfunction

endpackage

// File: rtl/hex_scan_timer.sv
// Slot timing: blank-phase counter, PWM step prescaler and step index k.
module hex_scan_timer
  import hex_display_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES = 64,
  parameter int unsigned STEP_CYCLES  = 256
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       on_i,          // FSM is in the ON phase
  output logic       blank_first_o, // first cycle of a BLANK phase
  output logic       blank_done_o,  // last cycle of a BLANK phase
  output logic       step_done_o,   // last cycle of a PWM step
  output logic       slot_done_o,   // last cycle of the ON phase
  output logic [3:0] k_o
);

  localparam int unsigned BlankW = (BLANK_CYCLES > 1) ? $clog2(BLANK_CYCLES) : 1;
  localparam int unsigned StepW  = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic [BlankW-1:0] blank_cnt_q, blank_cnt_d;
  logic [StepW-1:0]  step_cnt_q, step_cnt_d;
  logic [3:0]        k_q, k_d;

  // Counters only advance in their own phase, so each enters it at zero.
  always_comb begin
    blank_cnt_d   = blank_cnt_q;
    step_cnt_d    = step_cnt_q;
    k_d           = k_q;
    blank_first_o = !on_i && (blank_cnt_q == '0);
    blank_done_o  = !on_i && (blank_cnt_q == BlankW'(BLANK_CYCLES - 1));
    step_done_o   = on_i && (step_cnt_q == StepW'(STEP_CYCLES - 1));
    slot_done_o   = step_done_o && (k_q == 4'(PWM_STEPS - 1));
    if (!on_i) begin
      blank_cnt_d = blank_done_o ? '0 : blank_cnt_q + 1'b1;
    end else begin
      step_cnt_d = step_done_o ? '0 : step_cnt_q + 1'b1;
      if (step_done_o) begin
        k_d = slot_done_o ? 4'd0 : k_q + 4'd1;
      end
    end
  end

  // Counter registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      blank_cnt_q <= '0;
      step_cnt_q  <= '0;
      k_q         <= 4'd0;
    end else begin
      blank_cnt_q <= blank_cnt_d;
      step_cnt_q  <= step_cnt_d;
      k_q         <= k_d;
    end
  end

  assign k_o = k_q;

endmodule

// File: rtl/hex_display_scan.sv
// Time-multiplexed 4-digit segment driver with blanking and PWM brightness.
module hex_display_scan
  import hex_display_pkg::*;
#(
  parameter int unsigned BLANK_CYCLES   = 64,
  parameter int unsigned STEP_CYCLES    = 256,
  parameter bit          SEG_ACTIVE_LOW = 1'b1,
  parameter bit          DIG_ACTIVE_LOW = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] hex0_i,
  input  logic [7:0] hex1_i,
  input  logic [7:0] hex2_i,
  input  logic [7:0] hex3_i,
  input  logic       en_i,
  input  logic [3:0] bright_i,
  output logic [7:0] seg_o,
  output logic [3:0] dig_o,
  output logic       frame_o
);

  localparam logic [7:0] SegIdle = seg_idle(SEG_ACTIVE_LOW);
  localparam logic [3:0] DigOff  = DIG_ACTIVE_LOW ? 4'hF : 4'h0;

  state_e     state_q, state_d;
  logic [1:0] idx_q, idx_d;
  logic [7:0] pat_q, pat_d;
  logic [3:0] lvl_q, lvl_d;
  logic       frame_pend_q, frame_pend_d;
  logic [7:0] seg_q, seg_d;
  logic [3:0] dig_q, dig_d;
  logic       frame_q;

  logic       blank_first, blank_done, step_done, slot_done;
  logic [3:0] k;
  logic [7:0] hex_sel;
  logic [3:0] dig_onehot;
  logic       lit;

  hex_scan_timer #(
    .BLANK_CYCLES (BLANK_CYCLES),
    .STEP_CYCLES  (STEP_CYCLES)
  ) u_timer (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .on_i          (state_q == ST_ON),
    .blank_first_o (blank_first),
    .blank_done_o  (blank_done),
    .step_done_o   (step_done),
    .slot_done_o   (slot_done),
    .k_o           (k)
  );

  // Pattern for the digit currently being scanned.
  always_comb begin
    hex_sel = hex0_i;
    unique case (idx_q)
      2'd0: hex_sel = hex0_i;
      2'd1: hex_sel = hex1_i;
      2'd2: hex_sel = hex2_i;
      2'd3: hex_sel = hex3_i;
      default: hex_sel = hex0_i;
    endcase
  end

  // FSM next state, per-slot latches and registered output decode.
  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    pat_d        = pat_q;
    lvl_d        = lvl_q;
    frame_pend_d = 1'b0;
    unique case (state_q)
      ST_BLANK: begin
        // Snapshot inputs once per slot so a slot never tears.
        if (blank_first) begin
          pat_d = hex_sel;
          lvl_d = bright_i;
        end
        if (blank_done) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (slot_done) begin
          state_d      = ST_BLANK;
          idx_d        = idx_q + 2'd1;
          // Delayed one more cycle so it lines up with the output registers.
          frame_pend_d = (idx_q == 2'(NUM_DIGITS - 1));
        end
      end
      default: state_d = ST_BLANK;
    endcase

    lit        = (state_q == ST_ON) && (k <= lvl_q) && en_i;
    dig_onehot = 4'b0001 << idx_q;
    seg_d      = lit ? pat_q : SegIdle;
    dig_d      = DigOff;
    if (lit) begin
      dig_d = DIG_ACTIVE_LOW ? ~dig_onehot : dig_onehot;
    end
  end

  // State, latches and pin-facing output registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= ST_BLANK;
      idx_q        <= 2'd0;
      pat_q        <= 8'h00;
      lvl_q        <= 4'd0;
      frame_pend_q <= 1'b0;
      seg_q        <= SegIdle;
      dig_q        <= DigOff;
      frame_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      pat_q        <= pat_d;
      lvl_q        <= lvl_d;
      frame_pend_q <= frame_pend_d;
      seg_q        <= seg_d;
      dig_q        <= dig_d;
      frame_q      <= frame_pend_q;
    end
  end

  assign seg_o   = seg_q;
  assign dig_o   = dig_q;
  assign frame_o = frame_q;

  // step_done only feeds slot_done inside the timer.
  logic unused_step_done;
  assign unused_step_done = step_done;

endmodule

// File: tb/tb_hex_display_scan.sv
// Randomised bench for hex_display_scan against a slot/frame arithmetic model.
module tb_hex_display_scan;

  localparam int Blank = 2;
  localparam int Step  = 1;
  localparam int Slot  = Blank + 16 * Step;
  localparam int Frame = 4 * Slot;

  logic       clk = 1'b0;
  logic       rst_i;
  logic [7:0] hex0_i, hex1_i, hex2_i, hex3_i;
  logic       en_i;
  logic [3:0] bright_i;
  logic [7:0] seg_o;
  logic [3:0] dig_o;
  logic       frame_o;

  hex_display_scan #(
    .BLANK_CYCLES   (Blank),
    .STEP_CYCLES    (Step),
    .SEG_ACTIVE_LOW (1'b1),
    .DIG_ACTIVE_LOW (1'b1)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst_i),
    .hex0_i   (hex0_i),
    .hex1_i   (hex1_i),
    .hex2_i   (hex2_i),
    .hex3_i   (hex3_i),
    .en_i     (en_i),
    .bright_i (bright_i),
    .seg_o    (seg_o),
    .dig_o    (dig_o),
    .frame_o  (frame_o)
  );

  always #5 clk = ~clk;

  int         n_cmp = 0;
  int         n_bad = 0;
  int         s;        // cycles since reset release (state time)
  logic [7:0] m_pat;    // model's per-slot snapshot
  logic [3:0] m_lvl;
  int         lit_cnt;
  int         frame_cnt;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] hex_of(input int d);
    case (d)
      0: return hex0_i;
      1: return hex1_i;
      2: return hex2_i;
      default: return hex3_i;
    endcase
  endfunction

  // One clock: predict from slot arithmetic, advance, compare.
  task automatic tick();
    int         pos, dig;
    bit         lit;
    logic [7:0] e_seg;
    logic [3:0] e_dig;
    logic       e_frame;
    pos = s % Slot;
    dig = (s / Slot) % 4;
    if (pos == 0) begin
      m_pat = hex_of(dig);
      m_lvl = bright_i;
    end
    lit     = (pos >= Blank) && (((pos - Blank) / Step) <= int'(m_lvl)) && en_i;
    e_seg   = lit ? m_pat : 8'hFF;
    e_dig   = lit ? ~(4'b0001 << dig) : 4'hF;
    e_frame = (s > 0) && (s % Frame == 0);
    @(posedge clk);
    #1;
    check_eq($sformatf("seg@%0d", s + 1), seg_o, e_seg);
    check_eq($sformatf("dig@%0d", s + 1), dig_o, e_dig);
    check_eq($sformatf("frame@%0d", s + 1), frame_o, e_frame);
    if (dig_o != 4'hF) lit_cnt++;
    if (frame_o) frame_cnt++;
    s++;
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  initial begin
    rst_i    = 1'b1;
    hex0_i   = 8'hC0;
    hex1_i   = 8'hF9;
    hex2_i   = 8'hA4;
    hex3_i   = 8'hB0;
    en_i     = 1'b1;
    bright_i = 4'd15;
    s        = 0;
    m_pat    = 8'h00;
    m_lvl    = 4'd0;
    #1;
    check_eq("rst_seg", seg_o, 8'hFF);
    check_eq("rst_dig", dig_o, 4'hF);
    check_eq("rst_frame", frame_o, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Full-brightness scan over two frames: exactly one pulse lands in range.
    frame_cnt = 0;
    run(2 * Frame);
    check_eq("frames_2x", frame_cnt, 1);

    // Brightness 3 -> 4 lit cycles per digit; brightness 0 -> 1 per digit.
    bright_i = 4'd3;
    lit_cnt  = 0;
    run(Frame);
    check_eq("lit_b3", lit_cnt, 16);
    bright_i = 4'd0;
    lit_cnt  = 0;
    run(Frame);
    check_eq("lit_b0", lit_cnt, 4);

    // Pattern change mid digit-0 ON phase must not tear the slot.
    bright_i = 4'd15;
    run(10);
    hex0_i = 8'h80;
    run(Frame);

    // Drop enable for 10 cycles inside digit 1's ON phase.
    while (s % Frame != Slot + Blank + 5) tick();
    en_i = 1'b0;
    run(10);
    en_i      = 1'b1;
    frame_cnt = 0;
    while (s % Frame != 0) tick();
    run(Frame);
    check_eq("frames_after_en", frame_cnt, 1);

    // Random patterns, brightness and enable glitches.
    repeat (3 * Frame) begin
      if ($urandom_range(0, 9) == 0) begin
        case ($urandom_range(0, 3))
          0: hex0_i = 8'($urandom);
          1: hex1_i = 8'($urandom);
          2: hex2_i = 8'($urandom);
          default: hex3_i = 8'($urandom);
        endcase
      end
      if ($urandom_range(0, 19) == 0) bright_i = 4'($urandom);
      en_i = ($urandom_range(0, 15) != 0);
      tick();
    end

    // Asynchronous reset in the middle of digit 2's ON phase.
    en_i     = 1'b1;
    bright_i = 4'd15;
    while (s % Frame != 0) tick();
    while (s % Frame != 2 * Slot + Blank + 6) tick();
    check_eq("pre_rst_dig", dig_o, 4'hB);
    check_eq("pre_rst_seg", seg_o, hex2_i);
    #2;
    rst_i = 1'b1;
    #1;
    check_eq("async_rst_seg", seg_o, 8'hFF);
    check_eq("async_rst_dig", dig_o, 4'hF);
    check_eq("async_rst_frame", frame_o, 1'b0);
    @(negedge clk);
    rst_i = 1'b0;
    s     = 0;
    run(Frame + 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
